// File: rtl/vend_ctrl_param.sv
// Parametrised three-channel vending controller: credit accumulation, vend,
// coin rejection against a credit ceiling and serial change return.
//
// state  | meaning
// IDLE   | no credit held
// ACCUM  | credit below price
// READY  | credit covers price, buy accepted
// VEND   | one-cycle dispense, price deducted on exit
// CHANGE | one change_pulse per cycle until credit is zero
module vend_ctrl_param #(
  parameter int CREDIT_W    = 11,
  parameter int COIN0_VAL   = 50,
  parameter int COIN1_VAL   = 100,
  parameter int COIN2_VAL   = 500,
  parameter int PRICE       = 200,
  parameter int CHANGE_UNIT = 50,
  parameter int MAX_CREDIT  = 1000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [2:0]          coin,
  input  logic                buy,
  input  logic                cancel,
  output logic [CREDIT_W-1:0] credit,
  output logic [2:0]          state,
  output logic                vend,
  output logic                change_pulse,
  output logic                coin_reject
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ACCUM  = 3'd1,
    S_READY  = 3'd2,
    S_VEND   = 3'd3,
    S_CHANGE = 3'd4
  } state_e;

  localparam logic [CREDIT_W-1:0] C0_V    = CREDIT_W'(COIN0_VAL);
  localparam logic [CREDIT_W-1:0] C1_V    = CREDIT_W'(COIN1_VAL);
  localparam logic [CREDIT_W-1:0] C2_V    = CREDIT_W'(COIN2_VAL);
  localparam logic [CREDIT_W-1:0] PRICE_V = CREDIT_W'(PRICE);
  localparam logic [CREDIT_W-1:0] UNIT_V  = CREDIT_W'(CHANGE_UNIT);
  localparam logic [CREDIT_W:0]   MAX_V   = (CREDIT_W+1)'(MAX_CREDIT);

  logic [2:0]          coin_q, coin_trig_q;
  logic                buy_q, buy_trig_q, cancel_q, cancel_trig_q;
  state_e              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic                vend_q, vend_d, change_q, change_d, reject_q, reject_d;

  logic [CREDIT_W-1:0] coin_val;
  logic                coin_extra, any_coin, coin_fits;
  logic [CREDIT_W:0]   coin_sum;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      coin_q        <= '0;
      coin_trig_q   <= '0;
      buy_q         <= 1'b0;
      buy_trig_q    <= 1'b0;
      cancel_q      <= 1'b0;
      cancel_trig_q <= 1'b0;
    end else begin
      coin_q        <= coin;
      coin_trig_q   <= coin & ~coin_q;
      buy_q         <= buy;
      buy_trig_q    <= buy & ~buy_q;
      cancel_q      <= cancel;
      cancel_trig_q <= cancel & ~cancel_q;
    end
  end

  // Lowest coin index wins; any other simultaneous coin is flagged for rejection.
  always_comb begin
    coin_val   = '0;
    coin_extra = 1'b0;
    if (coin_trig_q[0]) begin
      coin_val   = C0_V;
      coin_extra = |coin_trig_q[2:1];
    end else if (coin_trig_q[1]) begin
      coin_val   = C1_V;
      coin_extra = coin_trig_q[2];
    end else if (coin_trig_q[2]) begin
      coin_val   = C2_V;
    end
  end

  assign any_coin  = |coin_trig_q;
  assign coin_sum  = {1'b0, credit_q} + {1'b0, coin_val};
  assign coin_fits = (coin_sum <= MAX_V);

  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    vend_d   = 1'b0;
    change_d = 1'b0;
    reject_d = 1'b0;
    case (state_q)
      S_IDLE, S_ACCUM, S_READY: begin
        if (cancel_trig_q && state_q != S_IDLE) begin
          state_d  = S_CHANGE;
          reject_d = any_coin;
        end else if (buy_trig_q && state_q == S_READY) begin
          state_d  = S_VEND;
          vend_d   = 1'b1;
          reject_d = any_coin;
        end else begin
          if (any_coin) begin
            if (coin_fits) begin
              credit_d = coin_sum[CREDIT_W-1:0];
              reject_d = coin_extra;
            end else begin
              reject_d = 1'b1;
            end
          end
          if (credit_d >= PRICE_V)   state_d = S_READY;
          else if (credit_d != '0)   state_d = S_ACCUM;
          else                       state_d = S_IDLE;
        end
      end
      S_VEND: begin
        credit_d = credit_q - PRICE_V;
        state_d  = (credit_d != '0) ? S_CHANGE : S_IDLE;
        reject_d = any_coin;
      end
      S_CHANGE: begin
        change_d = 1'b1;
        credit_d = credit_q - UNIT_V;
        if (credit_d == '0) state_d = S_IDLE;
        reject_d = any_coin;
      end
      default: begin
        state_d  = S_IDLE;
        credit_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      credit_q <= '0;
      vend_q   <= 1'b0;
      change_q <= 1'b0;
      reject_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      vend_q   <= vend_d;
      change_q <= change_d;
      reject_q <= reject_d;
    end
  end

  assign credit       = credit_q;
  assign state        = state_q;
  assign vend         = vend_q;
  assign change_pulse = change_q;
  assign coin_reject  = reject_q;

endmodule

// File: tb/tb_vend_ctrl_param.sv
// Directed bench for vend_ctrl_param: purchases, refunds, ceiling, coincident
// events and mid-refund reset, with hand-computed expectations.
module tb_vend_ctrl_param;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  coin;
  logic        buy, cancel;
  logic [10:0] credit;
  logic [2:0]  state;
  logic        vend, change_pulse, coin_reject;

  int n_tests = 0;
  int n_fail  = 0;
  int n_vend, n_chg, n_rej, run, max_run;

  vend_ctrl_param dut (
    .clk(clk), .rst(rst), .coin(coin), .buy(buy), .cancel(cancel),
    .credit(credit), .state(state), .vend(vend),
    .change_pulse(change_pulse), .coin_reject(coin_reject)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (vend) n_vend++;
    if (coin_reject) n_rej++;
    if (change_pulse) begin
      n_chg++;
      run++;
      if (run > max_run) max_run = run;
    end else begin
      run = 0;
    end
  endtask

  task automatic clr();
    n_vend = 0; n_chg = 0; n_rej = 0; run = 0; max_run = 0;
  endtask

  // One-cycle input pulse; the FSM result is visible after the second tick.
  task automatic drive(input logic [2:0] c, input logic b, input logic x);
    coin = c; buy = b; cancel = x;
    tick();
    coin = '0; buy = 1'b0; cancel = 1'b0;
    tick();
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int k = 0;
    while (state !== 3'd0 && k < budget) begin
      tick();
      k++;
    end
    check(tag, state, 0);
    tick();
  endtask

  initial begin
    rst = 1'b0; coin = '0; buy = 1'b0; cancel = 1'b0;
    clr();
    repeat (2) @(negedge clk);
    check("rst_credit", credit, 0);
    check("rst_state", state, 0);
    check("rst_vend", vend, 0);
    check("rst_change", change_pulse, 0);
    check("rst_reject", coin_reject, 0);
    rst = 1'b1;
    repeat (2) tick();

    // exact purchase
    drive(3'b001, 0, 0); check("ex_c1", credit, 50);  check("ex_s1", state, 1); tick();
    drive(3'b001, 0, 0); check("ex_c2", credit, 100); check("ex_s2", state, 1); tick();
    drive(3'b001, 0, 0); check("ex_c3", credit, 150); check("ex_s3", state, 1); tick();
    drive(3'b001, 0, 0); check("ex_c4", credit, 200); check("ex_s4", state, 2); tick();
    clr();
    drive(3'b000, 1, 0);
    check("ex_vend", vend, 1);
    check("ex_svend", state, 3);
    tick();
    check("ex_vend_off", vend, 0);
    check("ex_cred0", credit, 0);
    check("ex_idle", state, 0);
    repeat (5) tick();
    check("ex_nvend", n_vend, 1);
    check("ex_nchg", n_chg, 0);

    // purchase with change
    drive(3'b100, 0, 0); check("pc_c500", credit, 500); check("pc_ready", state, 2); tick();
    clr();
    drive(3'b000, 1, 0);
    check("pc_vend", vend, 1);
    tick();
    check("pc_c300", credit, 300);
    check("pc_schg", state, 4);
    wait_idle(20, "pc_idle");
    check("pc_nchg", n_chg, 6);
    check("pc_run", max_run, 6);
    check("pc_nvend", n_vend, 1);
    check("pc_c0", credit, 0);

    // cancel refund, buy ignored with insufficient credit
    drive(3'b010, 0, 0); check("cr_c100", credit, 100); check("cr_accum", state, 1); tick();
    clr();
    drive(3'b000, 1, 0);
    check("cr_buy_ign_s", state, 1);
    check("cr_buy_ign_c", credit, 100);
    drive(3'b000, 0, 1);
    check("cr_schg", state, 4);
    wait_idle(20, "cr_idle");
    check("cr_nchg", n_chg, 2);
    check("cr_nvend", n_vend, 0);
    check("cr_c0", credit, 0);

    // ceiling and rejection during change
    drive(3'b100, 0, 0); tick();
    drive(3'b100, 0, 0); check("ce_c1000", credit, 1000); check("ce_ready", state, 2); tick();
    clr();
    drive(3'b001, 0, 0);
    check("ce_reject", coin_reject, 1);
    check("ce_c_hold", credit, 1000);
    tick();
    check("ce_rej_off", coin_reject, 0);
    drive(3'b000, 0, 1);
    check("ce_schg", state, 4);
    drive(3'b001, 0, 0);
    check("ce_rej_chg", coin_reject, 1);
    check("ce_still_chg", state, 4);
    wait_idle(40, "ce_idle");
    check("ce_nchg", n_chg, 20);
    check("ce_nrej", n_rej, 2);
    check("ce_c0", credit, 0);

    // reset mid-change
    drive(3'b100, 0, 0); tick();
    clr();
    drive(3'b000, 0, 1);
    check("rm_schg", state, 4);
    for (int k = 0; k < 20 && n_chg < 3; k++) tick();
    check("rm_3pulses", n_chg, 3);
    rst = 1'b0;
    #1;
    check("rm_c0", credit, 0);
    check("rm_s0", state, 0);
    check("rm_chg0", change_pulse, 0);
    repeat (2) tick();
    rst = 1'b1;
    repeat (5) tick();
    check("rm_nomore", n_chg, 3);
    drive(3'b010, 0, 0);
    check("rm_c100", credit, 100);
    drive(3'b000, 0, 1);
    wait_idle(20, "rm_idle");

    // coincident coins from zero credit
    clr();
    drive(3'b101, 0, 0);
    check("sc_c50", credit, 50);
    check("sc_rej", coin_reject, 1);
    tick();
    check("sc_nrej", n_rej, 1);
    drive(3'b001, 0, 0); check("sc_c100", credit, 100); tick();

    // coin together with cancel
    clr();
    drive(3'b010, 0, 1);
    check("cc_schg", state, 4);
    check("cc_c100", credit, 100);
    check("cc_rej", coin_reject, 1);
    wait_idle(20, "cc_idle");
    check("cc_nchg", n_chg, 2);
    check("cc_nrej", n_rej, 1);

    // held coin credited once
    clr();
    coin = 3'b010;
    repeat (20) tick();
    coin = 3'b000;
    repeat (3) tick();
    check("hd_c100", credit, 100);
    check("hd_s1", state, 1);
    check("hd_nrej", n_rej, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
